// File: rtl/bcd_7seg.sv
// bcd_7seg: binary-to-decimal conversion (shift-add-3) driving four active-low
// 7-segment displays, with one register stage on the outputs.
`default_nettype none

module bcd_7seg #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] b_in,
  output logic [0:6]   un,
  output logic [0:6]   dec,
  output logic [0:6]   cent,
  output logic [0:6]   mil
);

  localparam logic [0:6] C_SEG_DARK = 7'b1111111;

  logic [13:0] w_ext;
  logic [15:0] w_bcd;
  logic [0:6]  un_d,  dec_d,  cent_d,  mil_d;
  logic [0:6]  un_q,  dec_q,  cent_q,  mil_q;

  function automatic logic [0:6] seg_decode(input logic [3:0] digit);
    logic [0:6] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = C_SEG_DARK;
    endcase
    return seg;
  endfunction

  // N is limited to 1..13, so the zero-extension width is always at least one bit.
  assign w_ext = {{(14-N){1'b0}}, b_in};

  always_comb begin
    w_bcd = 16'd0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (w_bcd[4*d +: 4] > 4'd4) begin
          w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
        end
      end
      w_bcd = {w_bcd[14:0], w_ext[i]};
    end
  end

  always_comb begin
    un_d   = seg_decode(w_bcd[3:0]);
    dec_d  = seg_decode(w_bcd[7:4]);
    cent_d = seg_decode(w_bcd[11:8]);
    mil_d  = seg_decode(w_bcd[15:12]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      un_q   <= C_SEG_DARK;
      dec_q  <= C_SEG_DARK;
      cent_q <= C_SEG_DARK;
      mil_q  <= C_SEG_DARK;
    end else begin
      un_q   <= un_d;
      dec_q  <= dec_d;
      cent_q <= cent_d;
      mil_q  <= mil_d;
    end
  end

  assign un   = un_q;
  assign dec  = dec_q;
  assign cent = cent_q;
  assign mil  = mil_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_7seg.sv
// tb_bcd_7seg: directed and random checks of bcd_7seg (N=10) against a
// decimal reference model and the segment encoding table.
`default_nettype none

module tb_bcd_7seg;

  logic       clk;
  logic       rst_n;
  logic [9:0] b_in;
  logic [0:6] un, dec, cent, mil;

  int passed;
  int total;

  bcd_7seg #(.N(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .b_in (b_in),
    .un   (un),
    .dec  (dec),
    .cent (cent),
    .mil  (mil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:6] ref_seg(input int digit);
    case (digit)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [0:6] got, input logic [0:6] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic chk_value(input string tag, input int v);
    chk({tag, ".mil"},  mil,  ref_seg((v / 1000) % 10));
    chk({tag, ".cent"}, cent, ref_seg((v / 100) % 10));
    chk({tag, ".dec"},  dec,  ref_seg((v / 10) % 10));
    chk({tag, ".un"},   un,   ref_seg(v % 10));
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, ".mil"},  mil,  7'b1111111);
    chk({tag, ".cent"}, cent, 7'b1111111);
    chk({tag, ".dec"},  dec,  7'b1111111);
    chk({tag, ".un"},   un,   7'b1111111);
  endtask

  // Apply a value at the falling edge, then sample just after the next rising edge.
  task automatic apply(input int v);
    @(negedge clk);
    b_in = 10'(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    b_in   = 10'd123;

    // Reset held for two edges: outputs dark, input ignored.
    @(posedge clk); #1;
    chk_dark("reset1");
    @(posedge clk); #1;
    chk_dark("reset2");

    // Release: first edge loads 0123.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release.mil",  mil,  7'b0000001);
    chk("release.cent", cent, 7'b1001111);
    chk("release.dec",  dec,  7'b0010010);
    chk("release.un",   un,   7'b0000110);

    apply(0);
    chk("zero.mil",  mil,  7'b0000001);
    chk("zero.cent", cent, 7'b0000001);
    chk("zero.dec",  dec,  7'b0000001);
    chk("zero.un",   un,   7'b0000001);

    apply(1023);
    chk("full.mil",  mil,  7'b1001111);
    chk("full.cent", cent, 7'b0000001);
    chk("full.dec",  dec,  7'b0010010);
    chk("full.un",   un,   7'b0000110);

    apply(999);
    chk("v999.mil",  mil,  7'b0000001);
    chk("v999.cent", cent, 7'b0000100);
    chk("v999.dec",  dec,  7'b0000100);
    chk("v999.un",   un,   7'b0000100);

    apply(1000);
    chk("v1000.mil",  mil,  7'b1001111);
    chk("v1000.cent", cent, 7'b0000001);
    chk("v1000.dec",  dec,  7'b0000001);
    chk("v1000.un",   un,   7'b0000001);

    // Latency: 47 loaded, then 860 applied between edges must not show early.
    apply(47);
    chk_value("v47", 47);
    @(negedge clk);
    b_in = 10'd860;
    #2;
    chk("hold47.dec", dec, 7'b1001100);
    chk("hold47.un",  un,  7'b0001111);
    @(posedge clk); #1;
    chk("v860.mil",  mil,  7'b0000001);
    chk("v860.cent", cent, 7'b0000000);
    chk("v860.dec",  dec,  7'b0100000);
    chk("v860.un",   un,   7'b0000001);

    // Each digit value 0..9 in every position.
    for (int k = 0; k < 10; k++) begin
      apply(k * 111);
      chk_value("rep", k * 111);
    end

    // Mid-operation reset.
    @(negedge clk);
    rst_n = 1'b0;
    b_in  = 10'd555;
    @(posedge clk); #1;
    chk_dark("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_value("after_midreset", 555);

    // Random sweep.
    for (int k = 0; k < 250; k++) begin
      int v;
      v = int'($urandom_range(1023, 0));
      apply(v);
      chk_value("rand", v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
